// File: rtl/ofs_fim_pcie_ss_rx_multi_stream.sv
// ofs_fim_pcie_ss_rx_multi_stream
// N-way RX TLP splitter that sits on the FIM side after the RX CDC. Each packet
// is classified at SOP from the fmt/type byte of its side-band header:
//   completions -> stream 0, requests -> stream 1,
//   messages -> stream 2 (NUM_STREAMS==3) or stream 1 (NUM_STREAMS==2).
// Every stream owns a FIFO with a registered output stage, so a stalled
// consumer only blocks packets routed to it. Per-stream free-entry counts are
// exported for RX credit generation.
// Optional feature: define OFS_FIM_RX_MULTI_STREAM_STATS_EN to add per-stream
// packet counters (pkt_cnt) and a sticky reserved-type flag (proto_err).

module ofs_fim_pcie_ss_rx_multi_stream #(
  parameter int DATA_W      = 512,
  parameter int HDR_W       = 256,
  parameter int NUM_STREAMS = 2,
  parameter int DEPTH       = 64,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  // Input AXI-S
  input  logic                            in_tvalid,
  output logic                            in_tready,
  input  logic [DATA_W-1:0]               in_tdata,
  input  logic [DATA_W/8-1:0]             in_tkeep,
  input  logic                            in_tlast,
  input  logic [HDR_W-1:0]                in_tuser_hdr,
  input  logic                            in_tuser_vendor,
  // Per-stream output AXI-S
  output logic [NUM_STREAMS-1:0]          out_tvalid,
  input  logic [NUM_STREAMS-1:0]          out_tready,
  output logic [NUM_STREAMS*DATA_W-1:0]   out_tdata,
  output logic [NUM_STREAMS*DATA_W/8-1:0] out_tkeep,
  output logic [NUM_STREAMS-1:0]          out_tlast,
  output logic [NUM_STREAMS*HDR_W-1:0]    out_tuser_hdr,
  output logic [NUM_STREAMS-1:0]          out_tuser_vendor,
`ifdef OFS_FIM_RX_MULTI_STREAM_STATS_EN
  output logic [NUM_STREAMS*CNT_W-1:0]    free_entries,
  output logic [NUM_STREAMS*32-1:0]       pkt_cnt,
  output logic                            proto_err
`else
  output logic [NUM_STREAMS*CNT_W-1:0]    free_entries
`endif
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int ENT_W  = DATA_W + KEEP_W + HDR_W + 2;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int SEL_W  = (NUM_STREAMS > 2) ? 2 : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Elaboration-time parameter sanity
  if (NUM_STREAMS != 2 && NUM_STREAMS != 3) begin : g_bad_streams
    $error("ofs_fim_pcie_ss_rx_multi_stream: NUM_STREAMS must be 2 or 3");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ofs_fim_pcie_ss_rx_multi_stream: DEPTH must be a power of two >= 4");
  end

  typedef enum logic {
    ST_IDLE   = 1'b0,  // next accepted beat is a SOP
    ST_IN_PKT = 1'b1   // mid packet, routing held in r_sel
  } state_t;

  state_t            r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [HDR_W-1:0]  r_hdr;
  logic              r_rdy_en;

  logic [7:0]             w_ft;
  logic [SEL_W-1:0]       w_cls;
  logic [SEL_W-1:0]       w_sel;
  logic [NUM_STREAMS-1:0] w_full;
  logic                   w_accept;
  logic [HDR_W-1:0]       w_hdr_wr;
  logic [ENT_W-1:0]       w_entry;

  // Map the fmt/type byte onto a destination stream.
  function automatic logic [SEL_W-1:0] classify(input logic [7:0] ft);
    if (ft[4:1] == 4'b0101) begin
      return SEL_W'(0);
    end else if (ft[4:3] == 2'b10 && NUM_STREAMS == 3) begin
      return SEL_W'(2);
    end else begin
      return SEL_W'(1);
    end
  endfunction

  assign w_ft  = in_tuser_hdr[31:24];
  assign w_cls = classify(w_ft);
  assign w_sel = (r_state == ST_IDLE) ? w_cls : r_sel;

  // NOTE: in IDLE the ready term looks only at registered FIFO state, never at
  // in_tvalid or the header, so the handshake cannot form a combinational loop
  // with an upstream that waits for ready before asserting valid.
  assign in_tready = r_rdy_en && !rst &&
                     ((r_state == ST_IDLE) ? !(|w_full) : !w_full[r_sel]);
  assign w_accept  = in_tvalid && in_tready;

  // Non-SOP beats carry the header captured at SOP.
  assign w_hdr_wr = (r_state == ST_IDLE) ? in_tuser_hdr : r_hdr;
  assign w_entry  = {in_tuser_vendor, in_tlast, w_hdr_wr, in_tkeep, in_tdata};

  // Packet framing FSM: tracks SOP vs mid-packet and latches routing + header.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_hdr    <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            if (!in_tlast) begin
              r_state <= ST_IN_PKT;
              r_sel   <= w_cls;
              r_hdr   <= in_tuser_hdr;
            end
          end
          ST_IN_PKT: begin
            if (in_tlast) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Per-stream FIFO: an output register holds the head entry, the memory holds
  // the rest. Occupancy counts both, so at most DEPTH-1 entries sit in memory.
  for (genvar k = 0; k < NUM_STREAMS; k++) begin : g_stream
    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_free;
    logic             r_vld;
    logic [ENT_W-1:0] r_out;

    logic             w_push;
    logic             w_pop;
    logic             w_mem_empty;
    logic             w_bypass;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_push      = w_accept && (w_sel == SEL_W'(k));
    assign w_pop       = r_vld && out_tready[k];
    assign w_mem_empty = (r_count == {{(CNT_W-1){1'b0}}, r_vld});
    // Write straight into the output stage when it is (or is becoming) free.
    assign w_bypass    = w_push && (!r_vld || (w_pop && w_mem_empty));
    assign w_full[k]   = (r_count == DEPTH_C);
    assign w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, w_push}
                                 - {{(CNT_W-1){1'b0}}, w_pop};

    // Storage array write port.
    // NOTE: the memory has no reset; validity is tracked by the pointers and
    // occupancy, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
      if (w_push && !w_bypass) begin
        r_mem[r_wr_ptr] <= w_entry;
      end
    end

    // Pointers, occupancy, free count and the registered output stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_free   <= DEPTH_C;
        r_vld    <= 1'b0;
        r_out    <= '0;
      end else begin
        if (w_push && !w_bypass) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_bypass) begin
          r_out <= w_entry;
          r_vld <= 1'b1;
        end else if (w_pop) begin
          if (!w_mem_empty) begin
            r_out    <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end else begin
            r_vld <= 1'b0;
          end
        end
        r_count <= w_count_nxt;
        r_free  <= DEPTH_C - w_count_nxt;
      end
    end

    assign out_tvalid[k]                       = r_vld;
    assign out_tdata[k*DATA_W +: DATA_W]       = r_out[DATA_W-1:0];
    assign out_tkeep[k*KEEP_W +: KEEP_W]       = r_out[DATA_W +: KEEP_W];
    assign out_tuser_hdr[k*HDR_W +: HDR_W]     = r_out[DATA_W+KEEP_W +: HDR_W];
    assign out_tlast[k]                        = r_out[ENT_W-2];
    assign out_tuser_vendor[k]                 = r_out[ENT_W-1];
    assign free_entries[k*CNT_W +: CNT_W]      = r_free;

`ifdef OFS_FIM_RX_MULTI_STREAM_STATS_EN
    logic [31:0] r_pkt_cnt;

    // Count packets (accepted tlast beats) routed to this stream; wraps at 2^32.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_pkt_cnt <= '0;
      end else if (w_push && in_tlast) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
    end

    assign pkt_cnt[k*32 +: 32] = r_pkt_cnt;
`endif
  end

`ifdef OFS_FIM_RX_MULTI_STREAM_STATS_EN
  logic r_proto_err;

  // Sticky flag for a SOP carrying the reserved fmt/type 8'hFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_proto_err <= 1'b0;
    end else if (w_accept && r_state == ST_IDLE && w_ft == 8'hFF) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_rx_multi_stream.sv
// Directed bench for ofs_fim_pcie_ss_rx_multi_stream: a 3-stream and a
// 2-stream instance share the input bus; each has its own tvalid/tready.

module tb_ofs_fim_pcie_ss_rx_multi_stream;

  localparam int DW = 64;
  localparam int HW = 64;
  localparam int KW = DW / 8;
  localparam int D  = 64;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          v3, v2;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic [HW-1:0] thdr;
  logic          tvend;
  logic          rdy3_o, rdy2_o;

  logic [2:0]      ov3, ordy3, olast3, ovend3;
  logic [3*DW-1:0] odata3;
  logic [3*KW-1:0] okeep3;
  logic [3*HW-1:0] ohdr3;
  logic [3*CW-1:0] free3;

  logic [1:0]      ov2, ordy2, olast2, ovend2;
  logic [2*DW-1:0] odata2;
  logic [2*KW-1:0] okeep2;
  logic [2*HW-1:0] ohdr2;
  logic [2*CW-1:0] free2;

`ifdef OFS_FIM_RX_MULTI_STREAM_STATS_EN
  logic [3*32-1:0] pkt3;
  logic            perr3;
  logic [2*32-1:0] pkt2;
  logic            perr2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ofs_fim_pcie_ss_rx_multi_stream #(
    .DATA_W(DW), .HDR_W(HW), .NUM_STREAMS(3), .DEPTH(D)
  ) u_dut3 (
    .clk(clk), .rst(rst),
    .in_tvalid(v3), .in_tready(rdy3_o), .in_tdata(tdata), .in_tkeep(tkeep),
    .in_tlast(tlast), .in_tuser_hdr(thdr), .in_tuser_vendor(tvend),
    .out_tvalid(ov3), .out_tready(ordy3), .out_tdata(odata3), .out_tkeep(okeep3),
    .out_tlast(olast3), .out_tuser_hdr(ohdr3), .out_tuser_vendor(ovend3),
`ifdef OFS_FIM_RX_MULTI_STREAM_STATS_EN
    .free_entries(free3), .pkt_cnt(pkt3), .proto_err(perr3)
`else
    .free_entries(free3)
`endif
  );

  ofs_fim_pcie_ss_rx_multi_stream #(
    .DATA_W(DW), .HDR_W(HW), .NUM_STREAMS(2), .DEPTH(D)
  ) u_dut2 (
    .clk(clk), .rst(rst),
    .in_tvalid(v2), .in_tready(rdy2_o), .in_tdata(tdata), .in_tkeep(tkeep),
    .in_tlast(tlast), .in_tuser_hdr(thdr), .in_tuser_vendor(tvend),
    .out_tvalid(ov2), .out_tready(ordy2), .out_tdata(odata2), .out_tkeep(okeep2),
    .out_tlast(olast2), .out_tuser_hdr(ohdr2), .out_tuser_vendor(ovend2),
`ifdef OFS_FIM_RX_MULTI_STREAM_STATS_EN
    .free_entries(free2), .pkt_cnt(pkt2), .proto_err(perr2)
`else
    .free_entries(free2)
`endif
  );

  function automatic logic [HW-1:0] mk_hdr(input logic [7:0] ft, input logic [15:0] tag);
    return {16'hBEEF, tag, ft, 24'h00_0010};
  endfunction

  // Present one beat to the selected DUT and return #1 after the accepting edge.
  task automatic send(input bit to3, input logic [HW-1:0] hdr,
                      input logic [DW-1:0] data, input bit last);
    int n;
    tdata = data;
    tkeep = data[7:0];
    tlast = last;
    thdr  = hdr;
    tvend = data[0];
    v3    = to3;
    v2    = !to3;
    #1;
    n = 0;
    while (!(to3 ? rdy3_o : rdy2_o) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL send_timeout got no tready after %0d cycles exp tready=1", n);
    end
    @(posedge clk);
    #1;
    v3 = 1'b0;
    v2 = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    v3    = 1'b0;
    v2    = 1'b0;
    tdata = '0; tkeep = '0; tlast = 1'b0; thdr = '0; tvend = 1'b0;
    ordy3 = 3'b111;
    ordy2 = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdy3_o !== 1'b0) begin errors++; $display("FAIL reset_tready_during_rst got %b exp 0", rdy3_o); end
    rst = 1'b0;
    #1;
    checks++; if (rdy3_o !== 1'b0) begin errors++; $display("FAIL reset_tready_before_edge got %b exp 0", rdy3_o); end
    @(posedge clk);
    #1;
    checks++; if (rdy3_o !== 1'b1) begin errors++; $display("FAIL reset_tready3_after got %b exp 1", rdy3_o); end
    checks++; if (rdy2_o !== 1'b1) begin errors++; $display("FAIL reset_tready2_after got %b exp 1", rdy2_o); end
    checks++; if (free3 !== {3{7'd64}}) begin errors++; $display("FAIL reset_free3 got %h exp %h", free3, {3{7'd64}}); end
    checks++; if (free2 !== {2{7'd64}}) begin errors++; $display("FAIL reset_free2 got %h exp %h", free2, {2{7'd64}}); end
    checks++; if (ov3 !== 3'b000 || ov2 !== 2'b00) begin errors++; $display("FAIL reset_tvalid got %b/%b exp 000/00", ov3, ov2); end
    checks++; if (odata3 !== '0 || olast3 !== 3'b000) begin errors++; $display("FAIL reset_outdata got %h last %b exp 0", odata3, olast3); end
  endtask

  task automatic test_route3();
    logic [DW-1:0] d;
    for (int b = 0; b < 3; b++) begin
      d = 64'hC0DE_0000_0000_0000 + 64'(b);
      send(1'b1, (b == 0) ? mk_hdr(8'h4A, 16'h0001) : mk_hdr(8'hEE, 16'hDEAD), d, b == 2);
      checks++; if (ov3 !== 3'b001) begin errors++; $display("FAIL cpl_valid beat%0d got %b exp 001", b, ov3); end
      checks++; if (odata3[0 +: DW] !== d) begin errors++; $display("FAIL cpl_data beat%0d got %h exp %h", b, odata3[0 +: DW], d); end
      checks++; if (ohdr3[0 +: HW] !== mk_hdr(8'h4A, 16'h0001)) begin errors++; $display("FAIL cpl_hdr beat%0d got %h exp %h", b, ohdr3[0 +: HW], mk_hdr(8'h4A, 16'h0001)); end
      checks++; if (olast3[0] !== (b == 2) || okeep3[0 +: KW] !== d[7:0]) begin errors++; $display("FAIL cpl_last_keep beat%0d got %b/%h exp %b/%h", b, olast3[0], okeep3[0 +: KW], b == 2, d[7:0]); end
    end
    d = 64'h1234_5678_9ABC_DEF1;
    send(1'b1, mk_hdr(8'h00, 16'h0002), d, 1'b1);
    checks++; if (ov3 !== 3'b010) begin errors++; $display("FAIL mrd_valid got %b exp 010", ov3); end
    checks++; if (odata3[DW +: DW] !== d || ovend3[1] !== 1'b1) begin errors++; $display("FAIL mrd_data got %h vend %b exp %h vend 1", odata3[DW +: DW], ovend3[1], d); end
    checks++; if (ohdr3[HW +: HW] !== mk_hdr(8'h00, 16'h0002)) begin errors++; $display("FAIL mrd_hdr got %h exp %h", ohdr3[HW +: HW], mk_hdr(8'h00, 16'h0002)); end
    d = 64'hAAAA_5555_0000_0030;
    send(1'b1, mk_hdr(8'h30, 16'h0003), d, 1'b1);
    checks++; if (ov3 !== 3'b100) begin errors++; $display("FAIL msg_valid got %b exp 100", ov3); end
    checks++; if (odata3[2*DW +: DW] !== d) begin errors++; $display("FAIL msg_data got %h exp %h", odata3[2*DW +: DW], d); end
    @(posedge clk);
    #1;
    checks++; if (ov3 !== 3'b000) begin errors++; $display("FAIL route3_drained got %b exp 000", ov3); end
  endtask

  task automatic test_route2();
    logic [DW-1:0] d;
    d = 64'h0000_7272_0000_0072;
    send(1'b0, mk_hdr(8'h72, 16'h0004), d, 1'b1);
    checks++; if (ov2 !== 2'b10) begin errors++; $display("FAIL msg2_valid got %b exp 10", ov2); end
    checks++; if (odata2[DW +: DW] !== d) begin errors++; $display("FAIL msg2_data got %h exp %h", odata2[DW +: DW], d); end
    checks++; if (ohdr2[HW +: HW] !== mk_hdr(8'h72, 16'h0004)) begin errors++; $display("FAIL msg2_hdr got %h exp %h", ohdr2[HW +: HW], mk_hdr(8'h72, 16'h0004)); end
  endtask

  task automatic test_full();
    ordy3 = 3'b110;
    for (int i = 0; i < D; i++) begin
      send(1'b1, mk_hdr(8'h4A, 16'(i)), 64'hF000 + 64'(i), 1'b1);
    end
    checks++; if (free3[0 +: CW] !== 7'd0) begin errors++; $display("FAIL full_free0 got %0d exp 0", free3[0 +: CW]); end
    checks++; if (free3[CW +: CW] !== 7'd64) begin errors++; $display("FAIL full_free1 got %0d exp 64", free3[CW +: CW]); end
    checks++; if (rdy3_o !== 1'b0) begin errors++; $display("FAIL full_tready got %b exp 0", rdy3_o); end
    checks++; if (ov3[0] !== 1'b1 || odata3[0 +: DW] !== 64'hF000) begin errors++; $display("FAIL full_head got %b/%h exp 1/f000", ov3[0], odata3[0 +: DW]); end
    ordy3[0] = 1'b1;
    #1;
    checks++; if (rdy3_o !== 1'b0) begin errors++; $display("FAIL full_read_same_cycle_tready got %b exp 0", rdy3_o); end
    @(posedge clk);
    #1;
    ordy3[0] = 1'b0;
    #1;
    checks++; if (free3[0 +: CW] !== 7'd1) begin errors++; $display("FAIL full_after_pop_free0 got %0d exp 1", free3[0 +: CW]); end
    checks++; if (rdy3_o !== 1'b1) begin errors++; $display("FAIL full_after_pop_tready got %b exp 1", rdy3_o); end
    checks++; if (odata3[0 +: DW] !== 64'hF001) begin errors++; $display("FAIL full_after_pop_head got %h exp f001", odata3[0 +: DW]); end
    ordy3 = 3'b111;
    repeat (D + 4) @(posedge clk);
    #1;
    checks++; if (free3[0 +: CW] !== 7'd64 || ov3 !== 3'b000) begin errors++; $display("FAIL full_drain got free %0d valid %b exp 64/000", free3[0 +: CW], ov3); end
  endtask

  task automatic test_reset_mid();
    ordy3 = 3'b101;
    send(1'b1, mk_hdr(8'h00, 16'h0005), 64'h5000, 1'b0);
    send(1'b1, mk_hdr(8'hEE, 16'h0000), 64'h5001, 1'b0);
    checks++; if (free3[CW +: CW] !== 7'd62 || ov3 !== 3'b010) begin errors++; $display("FAIL mid_pre_reset got free1 %0d valid %b exp 62/010", free3[CW +: CW], ov3); end
    pulse_reset();
    checks++; if (free3 !== {3{7'd64}} || ov3 !== 3'b000) begin errors++; $display("FAIL mid_flush got free %h valid %b exp %h/000", free3, ov3, {3{7'd64}}); end
    checks++; if (rdy3_o !== 1'b0) begin errors++; $display("FAIL mid_tready_low got %b exp 0", rdy3_o); end
    @(posedge clk);
    #1;
    checks++; if (rdy3_o !== 1'b1) begin errors++; $display("FAIL mid_tready_rise got %b exp 1", rdy3_o); end
    ordy3 = 3'b111;
    send(1'b1, mk_hdr(8'h4A, 16'h0006), 64'h6000, 1'b1);
    checks++; if (ov3 !== 3'b001) begin errors++; $display("FAIL mid_new_sop_valid got %b exp 001", ov3); end
    checks++; if (ohdr3[0 +: HW] !== mk_hdr(8'h4A, 16'h0006)) begin errors++; $display("FAIL mid_new_sop_hdr got %h exp %h", ohdr3[0 +: HW], mk_hdr(8'h4A, 16'h0006)); end
  endtask

`ifdef OFS_FIM_RX_MULTI_STREAM_STATS_EN
  task automatic test_stats();
    pulse_reset();
    @(posedge clk);
    #1;
    ordy3 = 3'b111;
    // One two-beat completion plus four single-beat ones: five packets.
    send(1'b1, mk_hdr(8'h4A, 16'h0010), 64'h7000, 1'b0);
    send(1'b1, mk_hdr(8'hEE, 16'h0000), 64'h7001, 1'b1);
    for (int i = 0; i < 4; i++) send(1'b1, mk_hdr(8'h4A, 16'h0011), 64'h7100 + 64'(i), 1'b1);
    for (int i = 0; i < 3; i++) send(1'b1, mk_hdr(8'h40, 16'h0012), 64'h7200 + 64'(i), 1'b1);
    checks++; if (pkt3[0 +: 32] !== 32'd5) begin errors++; $display("FAIL stats_cpl got %0d exp 5", pkt3[0 +: 32]); end
    checks++; if (pkt3[32 +: 32] !== 32'd3) begin errors++; $display("FAIL stats_req got %0d exp 3", pkt3[32 +: 32]); end
    checks++; if (pkt3[64 +: 32] !== 32'd0 || perr3 !== 1'b0) begin errors++; $display("FAIL stats_msg_err got %0d/%b exp 0/0", pkt3[64 +: 32], perr3); end
    send(1'b1, mk_hdr(8'hFF, 16'h0013), 64'h7300, 1'b1);
    checks++; if (perr3 !== 1'b1) begin errors++; $display("FAIL stats_proto_set got %b exp 1", perr3); end
    send(1'b1, mk_hdr(8'h4A, 16'h0014), 64'h7400, 1'b1);
    checks++; if (perr3 !== 1'b1 || pkt3[32 +: 32] !== 32'd4) begin errors++; $display("FAIL stats_proto_sticky got %b req %0d exp 1/4", perr3, pkt3[32 +: 32]); end
    pulse_reset();
    checks++; if (perr3 !== 1'b0 || pkt3 !== '0) begin errors++; $display("FAIL stats_reset got %b/%h exp 0/0", perr3, pkt3); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired exp run to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_route3();
    test_route2();
    test_full();
    test_reset_mid();
`ifdef OFS_FIM_RX_MULTI_STREAM_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
